dut_sweep_driver: RTL and testbench

Sequential stimulus/response engine for the generated combinational blocks: it drives every code on the 4-bit `input_data` bus of a block under test, waits a programmable settle time, and samples the 19-bit `output_data` response. Each sampled word goes out on a valid/ready capture port and is folded into a 32-bit MISR signature. The final signature is compared against a golden value. It sits between the block under test and the regression scoreboard / on-chip self-test controller.

---
 rtl/dut_sweep_driver.sv | 146 ++++++++++++++
 tb/tb_dut_sweep_driver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_sweep_driver.sv
// Sweep engine: drives every input code into a block under test, waits a settle time,
// samples its response, offers each word on a valid/ready port and folds it into a MISR.
module dut_sweep_driver #(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 19,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       expected_sig,
  output logic [IN_W-1:0]   drive_data,
  input  logic [OUT_W-1:0]  resp_data,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [IN_W-1:0]   cap_code,
  output logic [OUT_W-1:0]  cap_word,
  output logic              busy,
  output logic              done,
  output logic [31:0]       signature,
  output logic              mismatch
);

  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE - 1);
  localparam logic [IN_W-1:0] LAST_CODE   = {IN_W{1'b1}};
  localparam logic [IN_W-1:0] CODE_ONE    = IN_W'(1);
  localparam logic [31:0]     MISR_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0]     MISR_SEED   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_OFFER  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] settle_cnt;

  // One MISR step: shift with feedback, then fold in the zero-extended response word.
  function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [OUT_W-1:0] word);
    logic [31:0] shifted;
    shifted = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0000_0000);
    return shifted ^ 32'(word);
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort outranks every other transition out of a busy state.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SETTLE;
        else       state_next = ST_IDLE;
      end
      ST_SETTLE: begin
        if (abort)                   state_next = ST_IDLE;
        else if (settle_cnt == 8'd0) state_next = ST_SAMPLE;
        else                         state_next = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (abort) state_next = ST_IDLE;
        else       state_next = ST_OFFER;
      end
      ST_OFFER: begin
        if (abort)                        state_next = ST_IDLE;
        else if (!cap_ready)              state_next = ST_OFFER;
        else if (drive_data == LAST_CODE) state_next = ST_DONE;
        else                              state_next = ST_SETTLE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_data <= {IN_W{1'b0}};
      settle_cnt <= 8'd0;
      cap_valid  <= 1'b0;
      cap_code   <= {IN_W{1'b0}};
      cap_word   <= {OUT_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      signature  <= MISR_SEED;
      mismatch   <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      done <= (state_next == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            drive_data <= {IN_W{1'b0}};
            settle_cnt <= SETTLE_LOAD;
            signature  <= MISR_SEED;
            mismatch   <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!abort && settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        end
        ST_SAMPLE: begin
          if (!abort) begin
            cap_word  <= resp_data;
            cap_code  <= drive_data;
            cap_valid <= 1'b1;
            signature <= misr_next(signature, resp_data);
          end
        end
        ST_OFFER: begin
          // An abort in the handshake cycle drops the word without advancing the code.
          if (abort || cap_ready) begin
            cap_valid <= 1'b0;
            if (!abort && drive_data != LAST_CODE) begin
              drive_data <= drive_data + CODE_ONE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        ST_DONE: begin
          if (!abort) mismatch <= (signature != expected_sig);
        end
        default: begin
          cap_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut_sweep_driver.sv
// Randomized bench for dut_sweep_driver: a response table drives resp_data, and a
// sweep-level model predicts capture order, sweep length, signature and mismatch.
module tb_dut_sweep_driver;
  localparam int IN_W   = 4;
  localparam int OUT_W  = 19;
  localparam int NCODES = 16;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, cap_ready;
  logic [31:0] expected_sig;
  logic [IN_W-1:0] drive_data, cap_code;
  logic [OUT_W-1:0] resp_data, cap_word;
  logic cap_valid, busy, done, mismatch;
  logic [31:0] signature;

  logic start1, abort1, ready1;
  logic [31:0] exp_sig1;
  logic [IN_W-1:0] drive1, cap_code1;
  logic [OUT_W-1:0] resp1, cap_word1;
  logic cap_valid1, busy1, done1, mm1;
  logic [31:0] sig1;

  logic [OUT_W-1:0] lut [NCODES];
  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int exp_idx = 0, stalls = 0, start_cyc = 0, last_len = 0;
  bit in_sweep = 1'b0, mm_pending = 1'b0;
  logic [31:0] model_sig = 32'hFFFF_FFFF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign resp_data = lut[drive_data];
  assign resp1     = OUT_W'(drive1);

  dut_sweep_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected_sig(expected_sig),
    .drive_data(drive_data), .resp_data(resp_data), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_code(cap_code), .cap_word(cap_word), .busy(busy),
    .done(done), .signature(signature), .mismatch(mismatch));

  dut_sweep_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected_sig(exp_sig1),
    .drive_data(drive1), .resp_data(resp1), .cap_valid(cap_valid1),
    .cap_ready(ready1), .cap_code(cap_code1), .cap_word(cap_word1), .busy(busy1),
    .done(done1), .signature(sig1), .mismatch(mm1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [OUT_W-1:0] w);
    logic [31:0] t;
    t = s << 1;
    if (s[31]) t = t ^ 32'h04C1_1DB7;
    return t ^ {13'd0, w};
  endfunction

  function automatic logic [31:0] lut_sig();
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < NCODES; i++) s = misr(s, lut[i]);
    return s;
  endfunction

  function automatic logic [31:0] loop_sig();
    logic [31:0] s;
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < NCODES; i++) s = misr(s, OUT_W'(i));
    return s;
  endfunction

  // Compare process: captures in order, stable while stalled, sweep length, signature, mismatch.
  always @(negedge clk) begin
    if (rst) begin
      in_sweep   = 1'b0;
      mm_pending = 1'b0;
    end else begin
      if (mm_pending) begin
        chk("mismatch", mismatch, (model_sig != expected_sig));
        chk("done_pulse_width", done, 1'b0);
        mm_pending = 1'b0;
      end
      if (cap_valid) begin
        if (exp_idx < NCODES) begin
          chk("cap_code", cap_code, exp_idx);
          chk("cap_word", cap_word, lut[exp_idx[3:0]]);
          chk("drive_hold", drive_data, cap_code);
        end else begin
          chk("cap_overrun", exp_idx, NCODES - 1);
        end
        if (cap_ready && !abort) exp_idx++;
        else if (!cap_ready)     stalls++;
      end
      if (done) begin
        chk("done_in_sweep", in_sweep, 1'b1);
        chk("sweep_codes", exp_idx, NCODES);
        chk("sweep_len", cyc - start_cyc, NCODES * 4 + stalls);
        chk("signature", signature, model_sig);
        last_len   = cyc - start_cyc;
        in_sweep   = 1'b0;
        mm_pending = 1'b1;
      end
      if (start && !busy) begin
        in_sweep  = 1'b1;
        exp_idx   = 0;
        stalls    = 0;
        start_cyc = cyc + 1;
        model_sig = lut_sig();
      end
    end
  end

  // policy: 0 ready high, 1 stall 3 cycles on code 5, 2 random ready. Codes < 0 disable events.
  task automatic sweep(input int policy, input int abort_code, input int rst_code, input int glitch_code);
    int  stall_left;
    bit  fin, glitched;
    stall_left = 3;
    fin        = 1'b0;
    glitched   = 1'b0;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("seed", signature, 32'hFFFF_FFFF);
    chk("busy_after_start", busy, 1'b1);
    chk("drive_first", drive_data, 0);
    for (int t = 0; t < 600 && !fin; t++) begin
      cap_ready = 1'b1;
      if (policy == 1 && cap_valid && cap_code == 4'd5 && stall_left > 0) begin
        cap_ready = 1'b0;
        stall_left--;
      end else if (policy == 2) begin
        cap_ready = ($urandom_range(0, 3) != 0);
      end
      if (glitch_code >= 0 && !glitched && drive_data == glitch_code[IN_W-1:0]) begin
        start    = 1'b1;
        glitched = 1'b1;
      end
      if (rst_code >= 0 && cap_valid && cap_code == rst_code[IN_W-1:0]) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_drive", drive_data, 0);
        chk("rst_valid", cap_valid, 1'b0);
        chk("rst_code", cap_code, 0);
        chk("rst_word", cap_word, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sig", signature, 32'hFFFF_FFFF);
        chk("rst_mismatch", mismatch, 1'b0);
        rst      = 1'b0;
        in_sweep = 1'b0;
        fin      = 1'b1;
      end else if (abort_code >= 0 && cap_valid && cap_code == abort_code[IN_W-1:0]) begin
        abort     = 1'b1;
        cap_ready = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", cap_valid, 1'b0);
        chk("abort_drive", drive_data, abort_code);
        chk("abort_done", done, 1'b0);
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #2;
          chk("abort_no_done", done, 1'b0);
        end
        fin = 1'b1;
      end else begin
        @(posedge clk); #2;
        start = 1'b0;
        if (done) fin = 1'b1;
      end
    end
    if (!fin) chk("sweep_timeout", fin, 1'b1);
    cap_ready = 1'b1;
    start     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic settle1_sweep();
    int ncap, nbusy;
    bit fin;
    logic [31:0] m;
    m        = loop_sig();
    exp_sig1 = m;
    ncap     = 0;
    nbusy    = 0;
    fin      = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #2;
    start1 = 1'b0;
    for (int t = 0; t < 200 && !fin; t++) begin
      if (cap_valid1) begin
        chk("s1_code", cap_code1, ncap);
        chk("s1_word", cap_word1, ncap);
        ncap++;
      end
      if (done1)      fin = 1'b1;
      else if (busy1) nbusy++;
      if (!fin) begin
        @(posedge clk); #2;
      end
    end
    chk("s1_finished", fin, 1'b1);
    chk("s1_caps", ncap, NCODES);
    chk("s1_busy_cycles", nbusy, 48);
    chk("s1_sig", sig1, m);
    @(posedge clk); #2;
    chk("s1_mismatch", mm1, 1'b0);
    chk("s1_idle", busy1, 1'b0);
  endtask

  task automatic set_loopback();
    for (int i = 0; i < NCODES; i++) lut[i] = OUT_W'(i);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cap_ready = 1'b1; expected_sig = 32'd0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1; exp_sig1 = 32'd0;
    set_loopback();
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_valid", cap_valid, 1'b0);
    chk("reset_drive", drive_data, 0);
    chk("reset_sig", signature, 32'hFFFF_FFFF);
    chk("reset_mismatch", mismatch, 1'b0);
    chk("model_pin0", misr(32'hFFFF_FFFF, 19'd0), 32'hFB3E_E249);
    chk("model_pin1", misr(32'h0000_0000, 19'd13), 32'h0000_000D);
    chk("model_pin2", misr(32'h8000_0000, 19'h7FFFF), 32'h04C6_E248);
    chk("model_pin_loop", lut_sig(), loop_sig());
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    // Loopback sweep.
    expected_sig = lut_sig();
    sweep(0, -1, -1, -1);
    chk("loop_mismatch", mismatch, 1'b0);
    chk("loop_sig_hold", signature, loop_sig());
    chk("loop_len", last_len, 64);

    // Constant response, then a one-bit-off golden value.
    for (int i = 0; i < NCODES; i++) lut[i] = 19'd13;
    expected_sig = lut_sig();
    sweep(0, -1, -1, -1);
    chk("const_mismatch", mismatch, 1'b0);
    expected_sig = expected_sig ^ 32'h0000_0001;
    sweep(0, -1, -1, -1);
    chk("const_flip_mismatch", mismatch, 1'b1);

    // Backpressure on code 5.
    set_loopback();
    expected_sig = lut_sig();
    sweep(1, -1, -1, -1);
    chk("bp_len", last_len, 67);

    // Abort at code 7 in the handshake cycle, then a clean restart.
    sweep(0, 7, -1, -1);
    sweep(0, -1, -1, -1);
    chk("after_abort_sig", signature, loop_sig());

    // Asynchronous reset mid-sweep at code 9, then a clean sweep.
    sweep(0, -1, 9, -1);
    sweep(0, -1, -1, -1);
    chk("after_rst_sig", signature, loop_sig());

    // Start pulse while busy at code 3 must be ignored.
    sweep(0, -1, -1, 3);
    chk("glitch_len", last_len, 64);

    // Random responses, random backpressure, golden value sometimes corrupted.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NCODES; i++) lut[i] = OUT_W'($urandom);
      expected_sig = lut_sig();
      if ($urandom_range(0, 1) != 0) expected_sig = expected_sig ^ (32'h1 << $urandom_range(0, 31));
      sweep(2, -1, -1, -1);
    end

    settle1_sweep();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
